// File: rtl/arashi_pkg.sv
// arashi write-slot collector: shared types and sizing helpers.
// Imported by the interface, the popcount block and the collector top.
package arashi_pkg;

  localparam int THREAD_NUM_DEF = 4;
  localparam int MEM_WIDTH_DEF  = 4;
  localparam int DATA_WIDTH_DEF = 32;

  function automatic int depth_of(input int mem_width);
    return 1 << mem_width;
  endfunction

  localparam int DEPTH_DEF = depth_of(MEM_WIDTH_DEF);

  typedef logic [MEM_WIDTH_DEF-1:0]  slot_t;
  typedef logic [MEM_WIDTH_DEF:0]    cnt_t;
  typedef logic [DATA_WIDTH_DEF-1:0] data_t;

endpackage

// File: rtl/arashi_collector_if.sv
// Bus between the slot allocator / consumer and the collector.
// master drives writes and rd_ready; slave is the collector.
interface arashi_collector_if
  import arashi_pkg::*;
#(
  parameter int THREAD_NUM = THREAD_NUM_DEF,
  parameter int MEM_WIDTH  = MEM_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [THREAD_NUM-1:0]            wr;
  logic [MEM_WIDTH*THREAD_NUM-1:0]  maddr;
  logic [DATA_WIDTH*THREAD_NUM-1:0] wdata;
  logic                             rd_valid;
  logic                             rd_ready;
  logic [DATA_WIDTH-1:0]            rd_data;
  logic [MEM_WIDTH:0]               count;
  logic [MEM_WIDTH:0]               space;
  logic                             afull;
  logic                             overflow;

  modport master (
    output wr, maddr, wdata, rd_ready,
    input  rd_valid, rd_data, count,
    input  space, afull, overflow
  );

  modport slave (
    input  wr, maddr, wdata, rd_ready,
    output rd_valid, rd_data, count,
    output space, afull, overflow
  );

endinterface

// File: rtl/arashi_popcount.sv
// Generic population count of a strobe vector.
// Shared with the allocator side of the write path.
module arashi_popcount
  import arashi_pkg::*;
#(
  parameter int WIDTH = THREAD_NUM_DEF,
  parameter int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [OUT_W-1:0] cnt_o
);

  // Adder chain over the strobe bits
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_o = cnt_o + OUT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/arashi_collector.sv
// Circular slot buffer filled by per-thread writes and
// drained in slot order over a registered valid/ready port.
module arashi_collector
  import arashi_pkg::*;
#(
  parameter int THREAD_NUM = THREAD_NUM_DEF,
  parameter int MEM_WIDTH  = MEM_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  arashi_collector_if.slave  bus
);

  localparam int DEPTH = depth_of(MEM_WIDTH);
  localparam int CW    = MEM_WIDTH + 1;

  logic [MEM_WIDTH-1:0]  head_q, head_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [MEM_WIDTH-1:0]  addr_w [THREAD_NUM];
  logic [DATA_WIDTH-1:0] data_w [THREAD_NUM];
  logic [MEM_WIDTH-1:0]  rank   [THREAD_NUM];

  logic [CW-1:0]         n_wr;
  logic [CW-1:0]         space;
  logic [CW-1:0]         rem;
  logic [MEM_WIDTH-1:0]  tail;
  logic                  pop;
  logic                  ovf_now;

  for (genvar g = 0; g < THREAD_NUM; g++) begin : g_unpack
    assign addr_w[g] = bus.maddr[g*MEM_WIDTH +: MEM_WIDTH];
    assign data_w[g] = bus.wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  arashi_popcount #(
    .WIDTH (THREAD_NUM),
    .OUT_W (CW)
  ) u_popcount (
    .bits_i (bus.wr),
    .cnt_o  (n_wr)
  );

  assign space = CW'(DEPTH) - count_q;
  assign tail  = head_q + count_q[MEM_WIDTH-1:0];

  // Occupancy, overflow and choice of the next presented entry
  always_comb begin
    pop        = rd_valid_q && bus.rd_ready;
    ovf_now    = n_wr > space;
    count_d    = count_q + (ovf_now ? '0 : n_wr) - CW'(pop);
    ovf_d      = ovf_q || ovf_now;
    head_d     = head_q + MEM_WIDTH'(pop);
    rem        = count_q - CW'(pop);
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    // Only slots written at an earlier edge are in rem,
    // which gives the one-cycle read latency.
    if (!rd_valid_q || pop) begin
      rd_valid_d = rem != '0;
      if (rem != '0) begin
        rd_data_d = mem_q[head_d];
      end
    end
  end

  // Pointer, occupancy, presented entry and sticky error
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      ovf_q      <= ovf_d;
    end
  end

  // Per-thread slot writes; an overflowing cycle drops all
  always_ff @(posedge clk) begin
    if (rstn && !ovf_now) begin
      for (int i = 0; i < THREAD_NUM; i++) begin
        if (bus.wr[i]) begin
          mem_q[addr_w[i]] <= data_w[i];
        end
      end
    end
  end

  // Rank of each enabled thread among the enabled threads
  always_comb begin
    logic [MEM_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < THREAD_NUM; i++) begin
      rank[i] = acc;
      acc     = acc + MEM_WIDTH'(bus.wr[i]);
    end
  end

  // Allocator contract: distinct, contiguous slots from tail
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < THREAD_NUM; i++) begin
        if (bus.wr[i]) begin
          assert (addr_w[i] == MEM_WIDTH'(tail + rank[i]))
            else $error("maddr of thread %0d off tail", i);
          for (int j = i + 1; j < THREAD_NUM; j++) begin
            if (bus.wr[j]) begin
              assert (addr_w[i] != addr_w[j])
                else $error("threads %0d,%0d share slot", i, j);
            end
          end
        end
      end
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.count    = count_q;
  assign bus.space    = space;
  assign bus.afull    = space < CW'(THREAD_NUM);
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_arashi_collector.sv
// Randomised scoreboard bench for arashi_collector.
// Driver queues expected words; a monitor pops and compares.
module tb_arashi_collector;
  import arashi_pkg::*;

  localparam int TN = THREAD_NUM_DEF;
  localparam int MW = MEM_WIDTH_DEF;
  localparam int DW = DATA_WIDTH_DEF;

  typedef struct {
    data_t data;
    int    wedge;
  } ent_t;

  logic clk;
  logic rstn;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   m_head;
  logic m_ovf;
  ent_t exp_q[$];

  arashi_collector_if bus ();

  arashi_collector dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0h want %0h (cycle %0d)",
               name, got, want, cyc);
    end
  endtask

  // Monitor: expected rd_valid and data from the queued model
  initial begin
    logic exp_v;
    forever begin
      @(negedge clk);
      exp_v = (exp_q.size() != 0) &&
              (exp_q[0].wedge <= cyc - 1);
      chk("rd_valid", {63'd0, bus.rd_valid}, {63'd0, exp_v});
      if (exp_v && bus.rd_valid === 1'b1) begin
        chk("rd_data", {32'd0, bus.rd_data},
            {32'd0, exp_q[0].data});
        if (rstn && bus.rd_ready) begin
          void'(exp_q.pop_front());
          m_head++;
        end
      end
    end
  end

  task automatic status_chk();
    int   sz;
    cnt_t ec;
    sz = exp_q.size();
    ec = cnt_t'(sz);
    chk("count", {59'd0, bus.count}, {59'd0, ec});
    chk("space", {59'd0, bus.space},
        {59'd0, cnt_t'(DEPTH_DEF - sz)});
    chk("afull", {63'd0, bus.afull},
        {63'd0, (DEPTH_DEF - sz) < TN});
    chk("overflow", {63'd0, bus.overflow}, {63'd0, m_ovf});
  endtask

  // One clock: check status, issue writes, queue expectations
  task automatic step(input logic [TN-1:0] m, input logic rdy);
    int   sz;
    int   r;
    logic ovf;
    status_chk();
    sz  = exp_q.size();
    ovf = $countones(m) > DEPTH_DEF - sz;
    r   = 0;
    for (int i = 0; i < TN; i++) begin
      slot_t a;
      data_t d;
      d = $urandom;
      a = slot_t'(m_head + sz + r);
      if (!m[i]) a = slot_t'($urandom_range(0, DEPTH_DEF - 1));
      bus.maddr[i*MW +: MW] = a;
      bus.wdata[i*DW +: DW] = d;
      if (m[i]) begin
        r++;
        if (!ovf) exp_q.push_back('{data: d, wedge: cyc + 1});
      end
    end
    if (ovf) m_ovf = 1'b1;
    bus.wr       = m;
    bus.rd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rstn         = 1'b0;
    bus.wr       = '0;
    bus.rd_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    exp_q.delete();
    m_head = 0;
    m_ovf  = 1'b0;
    chk("rst_valid", {63'd0, bus.rd_valid}, 64'd0);
    chk("rst_data", {32'd0, bus.rd_data}, 64'd0);
    chk("rst_count", {59'd0, bus.count}, 64'd0);
    chk("rst_space", {59'd0, bus.space}, 64'(DEPTH_DEF));
    chk("rst_afull", {63'd0, bus.afull}, 64'd0);
    chk("rst_ovf", {63'd0, bus.overflow}, 64'd0);
    repeat (n - 1) @(posedge clk);
    if (n > 1) #1;
    rstn = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      step('0, 1'b1);
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain left %0d entries, want 0",
               exp_q.size());
    end
    step('0, 1'b1);
  endtask

  function automatic logic [TN-1:0] rmask();
    if (DEPTH_DEF - exp_q.size() < TN) return '0;
    return TN'($urandom_range(0, (1 << TN) - 1));
  endfunction

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    m_head       = 0;
    m_ovf        = 1'b0;
    rstn         = 1'b0;
    bus.wr       = '0;
    bus.maddr    = '0;
    bus.wdata    = '0;
    bus.rd_ready = 1'b0;
    do_reset(2);

    // Full-width burst, then in-order drain
    step(4'b1111, 1'b1);
    drain();

    // Sparse strobes
    do_reset(1);
    step(4'b1010, 1'b1);
    drain();

    // Fill to full through the afull threshold, then overflow
    do_reset(1);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0111, 1'b0);
    step(4'b0001, 1'b0);
    step('0, 1'b0);
    step('0, 1'b0);

    // Wrap: move head to 14, then push across the end
    do_reset(1);
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    step(4'b0011, 1'b1);
    drain();
    step(4'b1111, 1'b1);
    drain();

    // Stalled consumer while pushing, then release
    for (int i = 0; i < 5; i++) step(rmask(), 1'b0);
    drain();

    // Overflow with simultaneous pop, then reset mid-drain
    do_reset(1);
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b0);
    step('0, 1'b0);
    step('0, 1'b0);
    step(4'b0001, 1'b1);
    step('0, 1'b1);
    step('0, 1'b1);
    do_reset(1);
    step('0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(rmask(), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
